// File: rtl/hist_threshold_if.sv
// hist_threshold_if: histogram capture, parameters and result bus.
// Peak ports exist only with HIST_THRESH_PEAK_EN defined.
interface hist_threshold_if #(
  parameter int COUNT_W = 16,
  parameter int ACC_W   = 24
);
  logic                     i_hist_valid;
  logic [256*COUNT_W-1:0]   i_histogram;
  logic                     o_hist_ready;
  logic [ACC_W-1:0]         i_target;
  logic [7:0]               i_floor;
  logic                     o_valid;
  logic                     i_ready;
  logic [7:0]               o_threshold;
  logic [ACC_W-1:0]         o_count;
  logic                     o_found;
`ifdef HIST_THRESH_PEAK_EN
  logic [7:0]               o_peak_bin;
  logic [COUNT_W-1:0]       o_peak_count;
`endif

  modport slave (
    input  i_hist_valid,
    input  i_histogram,
    input  i_target,
    input  i_floor,
    input  i_ready,
    output o_hist_ready,
    output o_valid,
    output o_threshold,
    output o_count,
    output o_found
`ifdef HIST_THRESH_PEAK_EN
    ,
    output o_peak_bin,
    output o_peak_count
`endif
  );

  modport master (
    output i_hist_valid,
    output i_histogram,
    output i_target,
    output i_floor,
    output i_ready,
    input  o_hist_ready,
    input  o_valid,
    input  o_threshold,
    input  o_count,
    input  o_found
`ifdef HIST_THRESH_PEAK_EN
    ,
    input  o_peak_bin,
    input  o_peak_count
`endif
  );
endinterface

// File: rtl/hist_threshold.sv
// hist_threshold: captures a histogram, scans 255..floor for target count.
// Optional peak-bin tracking enabled by defining HIST_THRESH_PEAK_EN.
module hist_threshold #(
  parameter int COUNT_W = 16,
  parameter int ACC_W   = 24
) (
  input  logic i_clk,
  input  logic i_reset_n,
  hist_threshold_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [COUNT_W-1:0] r_bins [256];

  logic [7:0]       r_idx;
  logic [7:0]       w_idx_n;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_n;
  logic [ACC_W-1:0] r_tgt;
  logic [ACC_W-1:0] w_tgt_n;
  logic [7:0]       r_flr;
  logic [7:0]       w_flr_n;

  logic             r_hist_ready;
  logic             r_valid;
  logic [7:0]       r_thr;
  logic [7:0]       w_thr_n;
  logic [ACC_W-1:0] r_cnt;
  logic [ACC_W-1:0] w_cnt_n;
  logic             r_found;
  logic             w_found_n;

  logic             w_cap;
  logic [COUNT_W-1:0] w_bin;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_sat;

`ifdef HIST_THRESH_PEAK_EN
  logic [7:0]         r_pk_bin;
  logic [7:0]         w_pk_bin_n;
  logic [COUNT_W-1:0] r_pk_cnt;
  logic [COUNT_W-1:0] w_pk_cnt_n;
  logic [7:0]         r_peak_bin;
  logic [7:0]         w_peak_bin_n;
  logic [COUNT_W-1:0] r_peak_cnt;
  logic [COUNT_W-1:0] w_peak_cnt_n;
  logic               w_pk_upd;
  logic [7:0]         w_pk_bin_cur;
  logic [COUNT_W-1:0] w_pk_cnt_cur;
`endif

  assign w_cap = (r_state == S_IDLE)
               & r_hist_ready
               & bus.i_hist_valid;

  assign w_bin = r_bins[r_idx];
  assign w_sum = {1'b0, r_acc}
               + (ACC_W+1)'(w_bin);
  assign w_acc_sat = w_sum[ACC_W]
                   ? {ACC_W{1'b1}}
                   : w_sum[ACC_W-1:0];

`ifdef HIST_THRESH_PEAK_EN
  // Include the bin under scan; ties keep the brighter bin.
  assign w_pk_upd     = w_bin > r_pk_cnt;
  assign w_pk_bin_cur = w_pk_upd ? r_idx : r_pk_bin;
  assign w_pk_cnt_cur = w_pk_upd ? w_bin : r_pk_cnt;
`endif

  // Capture bank: upstream clears its bins right after the handshake.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 256; i++)
        r_bins[i] <= '0;
    end else if (w_cap) begin
      for (int i = 0; i < 256; i++)
        r_bins[i] <= bus.i_histogram[i*COUNT_W +: COUNT_W];
    end
  end

  // Next-state and next-register logic for the scan FSM.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_acc_n   = r_acc;
    w_tgt_n   = r_tgt;
    w_flr_n   = r_flr;
    w_thr_n   = r_thr;
    w_cnt_n   = r_cnt;
    w_found_n = r_found;
`ifdef HIST_THRESH_PEAK_EN
    w_pk_bin_n   = r_pk_bin;
    w_pk_cnt_n   = r_pk_cnt;
    w_peak_bin_n = r_peak_bin;
    w_peak_cnt_n = r_peak_cnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_cap) begin
          w_tgt_n   = bus.i_target;
          w_flr_n   = bus.i_floor;
          w_idx_n   = 8'd255;
          w_acc_n   = '0;
          w_state_n = S_SCAN;
`ifdef HIST_THRESH_PEAK_EN
          w_pk_bin_n = '0;
          w_pk_cnt_n = '0;
`endif
        end
      end
      S_SCAN: begin
`ifdef HIST_THRESH_PEAK_EN
        w_pk_bin_n = w_pk_bin_cur;
        w_pk_cnt_n = w_pk_cnt_cur;
`endif
        if (w_acc_sat >= r_tgt) begin
          w_thr_n   = r_idx;
          w_cnt_n   = w_acc_sat;
          w_found_n = 1'b1;
          w_state_n = S_DONE;
`ifdef HIST_THRESH_PEAK_EN
          w_peak_bin_n = w_pk_bin_cur;
          w_peak_cnt_n = w_pk_cnt_cur;
`endif
        end else if (r_idx == r_flr) begin
          w_thr_n   = r_idx;
          w_cnt_n   = w_acc_sat;
          w_found_n = 1'b0;
          w_state_n = S_DONE;
`ifdef HIST_THRESH_PEAK_EN
          w_peak_bin_n = w_pk_bin_cur;
          w_peak_cnt_n = w_pk_cnt_cur;
`endif
        end else begin
          w_acc_n = w_acc_sat;
          w_idx_n = r_idx - 8'd1;
        end
      end
      S_DONE: begin
        if (bus.i_ready)
          w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State, scan and registered result/handshake outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_acc        <= '0;
      r_tgt        <= '0;
      r_flr        <= '0;
      r_thr        <= '0;
      r_cnt        <= '0;
      r_found      <= 1'b0;
      r_hist_ready <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_idx        <= w_idx_n;
      r_acc        <= w_acc_n;
      r_tgt        <= w_tgt_n;
      r_flr        <= w_flr_n;
      r_thr        <= w_thr_n;
      r_cnt        <= w_cnt_n;
      r_found      <= w_found_n;
      r_hist_ready <= (w_state_n == S_IDLE);
      r_valid      <= (w_state_n == S_DONE);
    end
  end

`ifdef HIST_THRESH_PEAK_EN
  // Running peak during the scan and the reported peak.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pk_bin   <= '0;
      r_pk_cnt   <= '0;
      r_peak_bin <= '0;
      r_peak_cnt <= '0;
    end else begin
      r_pk_bin   <= w_pk_bin_n;
      r_pk_cnt   <= w_pk_cnt_n;
      r_peak_bin <= w_peak_bin_n;
      r_peak_cnt <= w_peak_cnt_n;
    end
  end

  assign bus.o_peak_bin   = r_peak_bin;
  assign bus.o_peak_count = r_peak_cnt;
`endif

  assign bus.o_hist_ready = r_hist_ready;
  assign bus.o_valid      = r_valid;
  assign bus.o_threshold  = r_thr;
  assign bus.o_count      = r_cnt;
  assign bus.o_found      = r_found;

endmodule

// File: tb/tb_hist_threshold.sv
// tb_hist_threshold: directed vectors for hist_threshold.
// A second narrow-accumulator instance exercises saturation.
module tb_hist_threshold;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [256*16-1:0] hist;

  hist_threshold_if #(.COUNT_W(16), .ACC_W(24)) bus ();
  hist_threshold_if #(.COUNT_W(16), .ACC_W(16)) bus2 ();

  hist_threshold #(.COUNT_W(16), .ACC_W(24)) u_dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  hist_threshold #(.COUNT_W(16), .ACC_W(16)) u_dut2 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input string tag,
                          input logic [23:0] tgt,
                          input logic [7:0]  flr,
                          input int          hold,
                          input logic [7:0]  e_thr,
                          input logic [23:0] e_cnt,
                          input logic        e_found,
                          input logic [7:0]  e_pbin,
                          input logic [15:0] e_pcnt);
    int n;
    n = 0;
    while (!bus.o_hist_ready && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, 32'(bus.o_hist_ready), 1);
    bus.i_histogram  = hist;
    bus.i_target     = tgt;
    bus.i_floor      = flr;
    bus.i_hist_valid = 1'b1;
    bus.i_ready      = (hold == 0);
    tick();
    bus.i_hist_valid = 1'b0;
    bus.i_histogram  = '0;
    bus.i_target     = '0;
    bus.i_floor      = 8'h55;
    check({tag, "_rdy_lo"}, 32'(bus.o_hist_ready), 0);
    n = 0;
    while (!bus.o_valid && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n + 1, 257 - int'(e_thr));
    check({tag, "_thr"}, 32'(bus.o_threshold), 32'(e_thr));
    check({tag, "_cnt"}, 32'(bus.o_count), 32'(e_cnt));
    check({tag, "_found"}, 32'(bus.o_found), 32'(e_found));
`ifdef HIST_THRESH_PEAK_EN
    check({tag, "_pbin"}, 32'(bus.o_peak_bin), 32'(e_pbin));
    check({tag, "_pcnt"}, 32'(bus.o_peak_count), 32'(e_pcnt));
`endif
    if (hold > 0) begin
      bus.i_histogram  = '1;
      bus.i_hist_valid = 1'b1;
      for (int k = 0; k < hold; k++) begin
        tick();
        check({tag, "_hold_v"}, 32'(bus.o_valid), 1);
        check({tag, "_hold_r"}, 32'(bus.o_hist_ready), 0);
        check({tag, "_hold_t"}, 32'(bus.o_threshold), 32'(e_thr));
        check({tag, "_hold_c"}, 32'(bus.o_count), 32'(e_cnt));
      end
      bus.i_hist_valid = 1'b0;
      bus.i_histogram  = '0;
      bus.i_ready      = 1'b1;
    end
    tick();
    bus.i_ready = 1'b0;
    check({tag, "_v_drop"}, 32'(bus.o_valid), 0);
    check({tag, "_rdy_up"}, 32'(bus.o_hist_ready), 1);
    check({tag, "_keep_t"}, 32'(bus.o_threshold), 32'(e_thr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.i_hist_valid  = 1'b0;
    bus.i_histogram   = '0;
    bus.i_target      = '0;
    bus.i_floor       = '0;
    bus.i_ready       = 1'b0;
    bus2.i_hist_valid = 1'b0;
    bus2.i_histogram  = '0;
    bus2.i_target     = '0;
    bus2.i_floor      = '0;
    bus2.i_ready      = 1'b0;
    tick();
    tick();
    check("rst_rdy", 32'(bus.o_hist_ready), 0);
    check("rst_v", 32'(bus.o_valid), 0);
    check("rst_thr", 32'(bus.o_threshold), 0);
    check("rst_cnt", 32'(bus.o_count), 0);
    check("rst_found", 32'(bus.o_found), 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_rdy", 32'(bus.o_hist_ready), 1);

    hist = '0;
    hist[255*16 +: 16] = 16'd3;
    hist[200*16 +: 16] = 16'd10;
    run_case("t1", 24'd12, 8'd0, 20,
             8'd200, 24'd13, 1'b1, 8'd200, 16'd10);

    hist = '0;
    run_case("t2", 24'd5, 8'd100, 0,
             8'd100, 24'd0, 1'b0, 8'd0, 16'd0);

    hist = '0;
    hist[255*16 +: 16] = 16'hFFFF;
    run_case("t3", 24'hFFFF, 8'd255, 0,
             8'd255, 24'hFFFF, 1'b1, 8'd255, 16'hFFFF);
    run_case("t3b", 24'd0, 8'd255, 0,
             8'd255, 24'hFFFF, 1'b1, 8'd255, 16'hFFFF);

    hist = '1;
    run_case("t4", 24'hFFFFFF, 8'd0, 0,
             8'd0, 24'hFFFF00, 1'b0, 8'd255, 16'hFFFF);

    hist = '0;
    hist[255*16 +: 16] = 16'h8000;
    hist[254*16 +: 16] = 16'h9000;
    bus2.i_histogram  = hist;
    bus2.i_target     = 16'hFFFF;
    bus2.i_floor      = 8'd0;
    bus2.i_hist_valid = 1'b1;
    bus2.i_ready      = 1'b1;
    check("sat_rdy", 32'(bus2.o_hist_ready), 1);
    tick();
    bus2.i_hist_valid = 1'b0;
    bus2.i_histogram  = '0;
    n = 0;
    while (!bus2.o_valid && n < 300) begin
      tick();
      n++;
    end
    check("sat_thr", 32'(bus2.o_threshold), 254);
    check("sat_cnt", 32'(bus2.o_count), 32'hFFFF);
    check("sat_found", 32'(bus2.o_found), 1);
    tick();
    bus2.i_ready = 1'b0;

    hist = '0;
    bus.i_histogram  = hist;
    bus.i_target     = 24'd5;
    bus.i_floor      = 8'd0;
    bus.i_hist_valid = 1'b1;
    tick();
    bus.i_hist_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst_n = 1'b0;
    #2;
    check("arst_rdy", 32'(bus.o_hist_ready), 0);
    check("arst_v", 32'(bus.o_valid), 0);
    check("arst_thr", 32'(bus.o_threshold), 0);
    check("arst_cnt", 32'(bus.o_count), 0);
    check("arst_found", 32'(bus.o_found), 0);
`ifdef HIST_THRESH_PEAK_EN
    check("arst_pbin", 32'(bus.o_peak_bin), 0);
    check("arst_pcnt", 32'(bus.o_peak_count), 0);
`endif
    tick();
    rst_n = 1'b1;

    hist = '0;
    hist[250*16 +: 16] = 16'd7;
    hist[240*16 +: 16] = 16'd7;
    run_case("pk", 24'd14, 8'd0, 0,
             8'd240, 24'd14, 1'b1, 8'd250, 16'd7);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
